// File: rtl/eth_mac_defs.sv
// Definitions shared by the Ethernet MAC transmit/receive blocks and their arbiters.
package eth_mac_defs;

  // Byte width of every AXI-Stream interface in the MAC datapath
  localparam int AXIS_W = 8;

  // TX arbiter states; the remaining encodings are illegal and recover to idle
  typedef enum logic [1:0] {
    ST_ARB_IDLE = 2'd0,
    ST_ARB_XFER = 2'd1
  } arb_state_e;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: the first requester found searching upward
// from (ptr + 1) mod NUM_PORTS wins. Shared by the TX arbiter and the RX queue scheduler.
module eth_rr_pick #(
  parameter  int NUM_PORTS = 4,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] onehot,
  output logic [PORT_W-1:0]    idx,
  output logic                 any
);

  // Scan candidates in priority order and keep the first one that requests
  always_comb begin
    int unsigned cand;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = (32'(ptr) + k) % NUM_PORTS;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = PORT_W'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the single byte-wide MAC TX stream.
// A grant is held from the first byte through the tlast handshake.
module eth_tx_arbiter
  import eth_mac_defs::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS*AXIS_W-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]          s_axis_tlast,
  output logic [NUM_PORTS-1:0]          s_axis_tready,
  output logic [AXIS_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic [NUM_PORTS-1:0]          port_enable,
  input  logic                          tx_pause,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [PORT_W-1:0]             grant_idx,
  output logic                          arb_busy,
  output logic [15:0]                   arb_frame_count
);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PORT_W-1:0]    grant_idx_q, grant_idx_d;
  logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

  logic [NUM_PORTS-1:0] pick_onehot;
  logic [PORT_W-1:0]    pick_idx;
  logic                 pick_any;

  logic [AXIS_W-1:0]    sel_data;
  logic                 sel_valid;
  logic                 sel_last;

  eth_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req    (s_axis_tvalid & port_enable),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // State, grant, round-robin pointer and frame counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= PORT_W'(NUM_PORTS - 1);
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Granted-port mux; loop compare avoids out-of-range part selects for non-power-of-2 port counts
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx_q == PORT_W'(i)) begin
        sel_data  = s_axis_tdata[i*AXIS_W +: AXIS_W];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  // Next-state logic and pass-through outputs
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    rr_ptr_d      = rr_ptr_q;
    frame_cnt_d   = frame_cnt_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      ST_ARB_IDLE: begin
        if (pick_any && !tx_pause) begin
          state_d     = ST_ARB_XFER;
          grant_d     = pick_onehot;
          grant_idx_d = pick_idx;
        end
      end
      ST_ARB_XFER: begin
        m_axis_tdata  = sel_data;
        m_axis_tvalid = sel_valid;
        m_axis_tlast  = sel_last;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (grant_idx_q == PORT_W'(i)) s_axis_tready[i] = m_axis_tready;
        end
        if (sel_valid && m_axis_tready && sel_last) begin
          state_d     = ST_ARB_IDLE;
          grant_d     = '0;
          rr_ptr_d    = grant_idx_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant           = grant_q;
  assign grant_idx       = grant_idx_q;
  assign arb_busy        = (state_q == ST_ARB_XFER);
  assign arb_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: frame-level source models, a MAC-side ready model and a
// bus-ownership reference model with per-port byte scoreboards.
module tb_eth_tx_arbiter;

  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP*8-1:0] s_axis_tdata;
  logic [NP-1:0]   s_axis_tvalid;
  logic [NP-1:0]   s_axis_tlast;
  logic [NP-1:0]   s_axis_tready;
  logic [7:0]      m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready;
  logic [NP-1:0]   port_enable;
  logic            tx_pause;
  logic [NP-1:0]   grant;
  logic [1:0]      grant_idx;
  logic            arb_busy;
  logic [15:0]     arb_frame_count;

  eth_tx_arbiter #(.NUM_PORTS(NP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .port_enable     (port_enable),
    .tx_pause        (tx_pause),
    .grant           (grant),
    .grant_idx       (grant_idx),
    .arb_busy        (arb_busy),
    .arb_frame_count (arb_frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Source side: bytes still to be offered, and bytes still expected at the MAC ({last, data})
  logic [8:0] src_q [NP][$];
  logic [8:0] exp_q [NP][$];
  int         frames_left [NP];
  int         len_fix [NP];
  logic       src_stall;
  int         mac_mode;
  int         cyc;
  logic [NP-1:0] hs_prev;

  // Reference model of bus ownership
  int          owner;
  int          rr;
  int          last_idx;
  logic [15:0] mcount;
  int          own_cycles;
  int          grant_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // Advance the stimulus by one clock: sources consume handshakes, new frames appear, ready updates
  task automatic cycle();
    int len;
    logic [8:0] b;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (hs_prev[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() == 0 && frames_left[i] > 0) begin
        frames_left[i]--;
        len = (len_fix[i] > 0) ? len_fix[i] : int'($urandom_range(1, 12));
        for (int n = 0; n < len; n++) begin
          b = {(n == len - 1), 8'($urandom_range(0, 255))};
          src_q[i].push_back(b);
          exp_q[i].push_back(b);
        end
      end
      if (src_q[i].size() > 0) begin
        s_axis_tvalid[i]       = !(src_stall && $urandom_range(0, 3) == 0);
        s_axis_tdata[8*i +: 8] = src_q[i][0][7:0];
        s_axis_tlast[i]        = src_q[i][0][8];
      end else begin
        s_axis_tvalid[i]       = 1'b0;
        s_axis_tdata[8*i +: 8] = 8'h00;
        s_axis_tlast[i]        = 1'b0;
      end
    end
    case (mac_mode)
      1:       m_axis_tready = ($urandom_range(0, 3) != 0);
      2:       m_axis_tready = (own_cycles >= 8) && (cyc % 3 != 0);
      default: m_axis_tready = 1'b1;
    endcase
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NP; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      frames_left[i] = 0;
    end
  endtask

  function automatic bit all_done();
    bit d = (owner < 0);
    for (int i = 0; i < NP; i++) if (src_q[i].size() != 0 || frames_left[i] != 0) d = 0;
    return d;
  endfunction

  task automatic wait_idle(input string nm, input int max);
    int n = 0;
    while (!all_done() && n < max) begin
      cycle();
      n++;
    end
    if (!all_done()) bound_fail(nm);
  endtask

  task automatic wait_owner(input string nm, input int p, input int max);
    int n = 0;
    while (owner != p && n < max) begin
      cycle();
      n++;
    end
    if (owner != p) bound_fail(nm);
  endtask

  task automatic do_reset();
    cycle();
    rst_n = 1'b0;
    clear_sources();
    cycle();
    cycle();
    grant_log.delete();
    rst_n = 1'b1;
  endtask

  // Compare process: check every output against the model, then advance the model across the next edge
  always @(negedge clk) begin
    logic [8:0] e;
    int p;
    if (!rst_n) begin
      owner      = -1;
      rr         = NP - 1;
      last_idx   = 0;
      mcount     = '0;
      own_cycles = 0;
      hs_prev    = '0;
      chk("rst_grant", grant, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_busy", arb_busy, 0);
      chk("rst_count", arb_frame_count, 0);
    end else begin
      if (owner >= 0) own_cycles++;
      chk("grant", grant, (owner >= 0) ? (32'd1 << owner) : 32'd0);
      chk("arb_busy", arb_busy, owner >= 0);
      chk("grant_idx", grant_idx, last_idx);
      chk("frame_count", arb_frame_count, mcount);
      chk("s_tready", s_axis_tready, (owner >= 0) ? (32'(m_axis_tready) << owner) : 32'd0);
      chk("m_tvalid", m_axis_tvalid, (owner >= 0) ? 32'(s_axis_tvalid[owner]) : 32'd0);
      if (owner < 0) begin
        chk("idle_tdata", m_axis_tdata, 0);
        chk("idle_tlast", m_axis_tlast, 0);
      end else if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q[owner].size() == 0) begin
          bound_fail("unexpected_byte");
        end else begin
          e = exp_q[owner].pop_front();
          chk("m_tdata", m_axis_tdata, e[7:0]);
          chk("m_tlast", m_axis_tlast, e[8]);
        end
      end
      hs_prev = s_axis_tvalid & s_axis_tready;
      if (owner >= 0) begin
        if (s_axis_tvalid[owner] && m_axis_tready && s_axis_tlast[owner]) begin
          rr     = owner;
          owner  = -1;
          mcount = mcount + 16'd1;
        end
      end else if (!tx_pause) begin
        for (int k = 1; k <= NP; k++) begin
          p = (rr + k) % NP;
          if (s_axis_tvalid[p] && port_enable[p]) begin
            owner      = p;
            last_idx   = p;
            own_cycles = 0;
            grant_log.push_back(p);
            break;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    port_enable   = '1;
    tx_pause      = 1'b0;
    src_stall     = 1'b0;
    mac_mode      = 0;
    cyc           = 0;
    hs_prev       = '0;
    owner         = -1;
    rr            = NP - 1;
    last_idx      = 0;
    mcount        = '0;
    own_cycles    = 0;
    for (int i = 0; i < NP; i++) begin
      frames_left[i] = 0;
      len_fix[i]     = 0;
    end

    repeat (3) cycle();
    settle();
    chk("t0_grant", grant, 0);
    chk("t0_count", arb_frame_count, 0);
    chk("t0_tvalid", m_axis_tvalid, 0);
    cycle();
    rst_n = 1'b1;

    // Single 10-byte frame on port 2: grant one cycle after tvalid
    len_fix[2] = 10;
    frames_left[2] = 1;
    cycle();
    settle();
    chk("t1_grant_same_cycle", grant, 0);
    cycle();
    settle();
    chk("t1_grant", grant, 4'b0100);
    wait_idle("t1_done", 200);
    chk("t1_count", arb_frame_count, 1);
    chk("t1_grant_after", grant, 0);
    chk("t1_drained", exp_q[2].size(), 0);

    // Ports 0, 1, 3 competing: strict round-robin order
    do_reset();
    len_fix[0] = 4; len_fix[1] = 4; len_fix[3] = 4;
    frames_left[0] = 2; frames_left[1] = 2; frames_left[3] = 2;
    wait_idle("t2_done", 300);
    chk("t2_log_size", grant_log.size(), 6);
    if (grant_log.size() == 6) begin
      chk("t2_order0", grant_log[0], 0);
      chk("t2_order1", grant_log[1], 1);
      chk("t2_order2", grant_log[2], 3);
      chk("t2_order3", grant_log[3], 0);
      chk("t2_order4", grant_log[4], 1);
      chk("t2_order5", grant_log[5], 3);
    end
    chk("t2_count", arb_frame_count, 6);

    // 64-byte frame with MAC backpressure
    mac_mode = 2;
    len_fix[0] = 64;
    frames_left[0] = 1;
    wait_idle("t3_done", 1000);
    mac_mode = 0;
    chk("t3_count", arb_frame_count, 7);
    chk("t3_drained", exp_q[0].size(), 0);

    // Pause raised mid-frame: current frame completes, no new grant until pause drops
    len_fix[1] = 8;
    frames_left[1] = 1;
    wait_owner("t4_owner1", 1, 50);
    repeat (3) cycle();
    tx_pause = 1'b1;
    len_fix[2] = 5;
    frames_left[2] = 1;
    begin
      int n = 0;
      while (!(owner < 0 && exp_q[1].size() == 0) && n < 100) begin
        cycle();
        n++;
      end
      if (!(owner < 0 && exp_q[1].size() == 0)) bound_fail("t4_port1_done");
    end
    repeat (5) cycle();
    settle();
    chk("t4_paused_grant", grant, 0);
    chk("t4_port2_waiting", exp_q[2].size(), 5);
    chk("t4_count", arb_frame_count, 8);
    cycle();
    tx_pause = 1'b0;
    settle();
    chk("t4_grant_same_cycle", grant, 0);
    cycle();
    settle();
    chk("t4_grant", grant, 4'b0100);
    wait_idle("t4_done", 100);
    chk("t4_count2", arb_frame_count, 9);

    // Disabled port never wins; disabling mid-frame does not cut the frame
    port_enable = 4'b1110;
    len_fix[0] = 6;
    frames_left[0] = 1;
    grant_log.delete();
    repeat (30) cycle();
    chk("t5_no_grant", grant_log.size(), 0);
    chk("t5_port0_pending", exp_q[0].size(), 6);
    port_enable = '1;
    wait_owner("t5_owner0", 0, 20);
    repeat (2) cycle();
    port_enable[0] = 1'b0;
    wait_idle("t5_done", 50);
    chk("t5_drained", exp_q[0].size(), 0);
    chk("t5_count", arb_frame_count, 10);
    port_enable = '1;

    // Reset mid-frame, then port 0 beats port 2
    len_fix[1] = 20;
    frames_left[1] = 1;
    wait_owner("t6_owner1", 1, 20);
    repeat (4) cycle();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_count", arb_frame_count, 0);
    clear_sources();
    grant_log.delete();
    cycle();
    cycle();
    len_fix[0] = 3; len_fix[2] = 3;
    frames_left[0] = 1; frames_left[2] = 1;
    cycle();
    rst_n = 1'b1;
    wait_idle("t6_done", 100);
    chk("t6_log_size", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t6_first", grant_log[0], 0);
      chk("t6_second", grant_log[1], 2);
    end

    // Randomized traffic: source stalls, MAC stalls, pause and enable churn
    src_stall = 1'b1;
    mac_mode  = 1;
    for (int i = 0; i < NP; i++) len_fix[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++)
        if (frames_left[i] == 0 && $urandom_range(0, 7) == 0) frames_left[i] = 1;
      if ($urandom_range(0, 19) == 0) tx_pause = ~tx_pause;
      if ($urandom_range(0, 29) == 0) port_enable = NP'($urandom);
      cycle();
    end
    tx_pause    = 1'b0;
    port_enable = '1;
    src_stall   = 1'b0;
    mac_mode    = 0;
    wait_idle("rand_drain", 2000);
    for (int i = 0; i < NP; i++) chk("rand_drained", exp_q[i].size(), 0);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
Frame-granular round-robin arbiter that shares the single byte-wide AXI-Stream input of the Ethernet MAC transmit path between NUM_PORTS requesters (e.g. CPU queue, ARP responder, DMA queue).
- Once a port is granted, the grant is held for the whole frame, up to and including the tlast handshake, so frames never interleave.
- Sits directly in front of the MAC TX; its master port connects to the MAC's s_axis_* input.
- Provides per-port enables, a global pause for flow control, and grant/statistics outputs.

Parameters:
NUM_PORTS, 4, number of requesting streams (2..8)
PORT_W, $clog2(NUM_PORTS), width of port index (derived localparam, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  NUM_PORTS*8  packed input bytes; port i at [8*i+7:8*i]
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tlast  in  NUM_PORTS  per-port end of frame
s_axis_tready  out  NUM_PORTS  per-port ready
m_axis_tdata  out  8  byte to MAC
m_axis_tvalid  out  1  valid to MAC
m_axis_tlast  out  1  last to MAC
m_axis_tready  in  1  ready from MAC
port_enable  in  NUM_PORTS  1 = port may win arbitration
tx_pause  in  1  1 = no new grants (flow control)
grant  out  NUM_PORTS  one-hot current grant; 0 when idle
grant_idx  out  PORT_W  index of current/last granted port
arb_busy  out  1  1 while a frame is in transfer
arb_frame_count  out  16  frames forwarded, wraps at 0xFFFF->0

Behaviour:
- Reset (async, rst_n low): state=ST_IDLE, grant=0, grant_idx=0, arb_busy=0, arb_frame_count=0, rr pointer=NUM_PORTS-1 (so port 0 has first priority). s_axis_tready=0 and m_axis_tvalid=0 throughout reset.
- States:
  - ST_IDLE: req[i] = s_axis_tvalid[i] & port_enable[i]. If req!=0 and !tx_pause, pick the first requesting port searching upward from (rr_ptr+1) mod NUM_PORTS. Register grant (one-hot) and grant_idx, set arb_busy=1, go to ST_XFER. Grant latency is 1 cycle from tvalid. Otherwise stay in ST_IDLE.
  - ST_XFER: pass-through, all combinational:
    - m_axis_tdata/tlast = granted port's byte/last
    - m_axis_tvalid = s_axis_tvalid[g]
    - s_axis_tready[g] = m_axis_tready; all other readies = 0
  - Exit from ST_XFER: on a handshake (m_axis_tvalid & m_axis_tready & m_axis_tlast), go to ST_IDLE next cycle. On that same edge: rr_ptr=grant_idx, grant=0, arb_busy=0, arb_frame_count+1. grant_idx keeps its value.
- Minimum gap: one idle cycle between consecutive frames, which is harmless given the MAC's IFG.
- Source stalls mid-frame (tvalid low): grant is held indefinitely; no timeout.
- Downstream stalls (the MAC deasserts ready during preamble, SFD, FCS and IFG): data is held; the arbiter never drops or duplicates bytes.
- port_enable deasserted or tx_pause asserted mid-frame: no effect until the current frame's tlast; both are evaluated only in ST_IDLE.
- Non-granted ports: s_axis_tready=0 always, whatever their tvalid.
- Simultaneous requests: strict round-robin. A port that just finished has lowest priority next round. A lone requester may win back-to-back frames.
- tlast on the first byte (1-byte frame) is legal: one XFER handshake, then back to IDLE.
- Unknown or illegal state: recovers to ST_IDLE with grant=0.
- Outputs when not in ST_XFER: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.

Decomposition:
- Shared package/header eth_mac_defs: state encodings ST_ARB_IDLE/ST_ARB_XFER, and the AXIS byte width constant (8) shared with the MAC TX/RX.
- One natural sub-module: eth_rr_pick. Combinational round-robin picker; inputs req[NUM_PORTS] and ptr[PORT_W]; outputs onehot[NUM_PORTS], idx[PORT_W], any. It is reusable for the RX-side queue scheduler.
- Top-level holds the FSM, grant registers, rr pointer, mux and counter.

Test Plan:
- Single port 2 requests a 10-byte frame, m_axis_tready tied 1 -> grant=4'b0100 one cycle after tvalid; bytes out in order; tlast on byte 10; arb_frame_count 0->1; grant=0 after.
- Ports 0,1,3 all request continuously -> grant order 0,1,3,0,1,3; one idle cycle between frames; no interleaving.
- MAC model deasserts tready for 8 cycles after grant and every 3rd cycle mid-frame -> all 64 bytes delivered exactly once; s_axis_tready[g] mirrors m_axis_tready.
- tx_pause=1 asserted mid-frame on port 1 -> frame completes; no new grant while paused with port 2 requesting; grant=4'b0100 one cycle after pause drops.
- port_enable[0]=0 with port 0 requesting -> never granted; port_enable toggled mid-frame -> current frame unaffected.
- rst_n pulsed low mid-frame -> grant, m_axis_tvalid and count go to 0 immediately; after release, port 0 wins first among ports 0 and 2.
